// File: rtl/multi_alarm_calendar.sv
// Calendar clock (sec..year, day of week) with NUM_ALARMS snoozable alarm channels, clocked by a 1 Hz Pulse.
// Define LEAP_YEAR_EN to give February 29 days when Year mod 4 = 0; otherwise February is always 28 days.

module mac_channel #(
    parameter int SNOOZE_MIN = 9,
    parameter int RING_SEC   = 60
) (
    input  logic       Pulse_i,
    input  logic       Reset_i,
    input  logic       on_i,
    input  logic       snooze_i,
    input  logic       edit_i,
    input  logic [5:0] nsec_i,
    input  logic [5:0] nmin_i,
    input  logic [4:0] nhrs_i,
    input  logic [5:0] cmin_i,
    input  logic [4:0] chrs_i,
    input  logic [5:0] amin_i,
    input  logic [4:0] ahrs_i,
    output logic       ring_o
);
    logic       ring_q, ring_d, pend_q, pend_d;
    logic [7:0] cnt_q, cnt_d;
    logic [5:0] smin_q, smin_d, tmin;
    logic [4:0] shrs_q, shrs_d, thrs;
    logic [6:0] msum;
    logic       hit;

    // Match against the time being loaded on this edge so ringing starts as the clock shows hh:mm:00.
    always_comb begin
        tmin   = pend_q ? smin_q : amin_i;
        thrs   = pend_q ? shrs_q : ahrs_i;
        hit    = (nsec_i == 6'd0) && (nmin_i == tmin) && (nhrs_i == thrs);
        msum   = {1'b0, cmin_i} + 7'(SNOOZE_MIN);
        ring_d = ring_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        smin_d = smin_q;
        shrs_d = shrs_q;
        if (!on_i) begin
            ring_d = 1'b0;
            pend_d = 1'b0;
            cnt_d  = 8'd0;
        end else if (ring_q && snooze_i) begin
            ring_d = 1'b0;
            pend_d = 1'b1;
            cnt_d  = 8'd0;
            if (msum >= 7'd60) begin
                smin_d = 6'(msum - 7'd60);
                shrs_d = (chrs_i == 5'd23) ? 5'd0 : chrs_i + 5'd1;
            end else begin
                smin_d = msum[5:0];
                shrs_d = chrs_i;
            end
        end else if (ring_q) begin
            if (cnt_q == 8'(RING_SEC - 1)) begin
                ring_d = 1'b0;
                cnt_d  = 8'd0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end else if (hit) begin
            ring_d = 1'b1;
            pend_d = 1'b0;
            cnt_d  = 8'd0;
        end
        if (edit_i) pend_d = 1'b0;
    end

    always_ff @(posedge Pulse_i or negedge Reset_i) begin
        if (!Reset_i) begin
            ring_q <= 1'b0;
            pend_q <= 1'b0;
            cnt_q  <= 8'd0;
            smin_q <= 6'd0;
            shrs_q <= 5'd0;
        end else begin
            ring_q <= ring_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            smin_q <= smin_d;
            shrs_q <= shrs_d;
        end
    end

    assign ring_o = ring_q;
endmodule

module multi_alarm_calendar #(
    parameter int NUM_ALARMS = 2,
    parameter int SNOOZE_MIN = 9,
    parameter int RING_SEC   = 60,
    localparam int SELW      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  Pulse_i,
    input  logic                  Reset_i,
    input  logic                  Timeset_i,
    input  logic                  Alarmset_i,
    input  logic [SELW-1:0]       Alarmsel_i,
    input  logic                  Minadv_i,
    input  logic                  Hrsadv_i,
    input  logic                  Dateadv_i,
    input  logic                  Monthadv_i,
    input  logic                  Yearadv_i,
    input  logic [NUM_ALARMS-1:0] Alarmon_i,
    input  logic                  Snooze_i,
    output logic [5:0]            Sec_o,
    output logic [5:0]            Min_o,
    output logic [4:0]            Hrs_o,
    output logic [2:0]            Dow_o,
    output logic [4:0]            Date_o,
    output logic [3:0]            Month_o,
    output logic [6:0]            Year_o,
    output logic [5:0]            DispMin_o,
    output logic [4:0]            DispHrs_o,
    output logic                  Buzz_o,
    output logic [NUM_ALARMS-1:0] BuzzCh_o
);
    logic [5:0] sec_q, sec_d, min_q, min_d, dmin_q, dmin_d;
    logic [4:0] hrs_q, hrs_d, date_q, date_raw, date_d, dhrs_q, dhrs_d, dim_cur, dim_nxt;
    logic [2:0] dow_q, dow_d;
    logic [3:0] mon_q, mon_d;
    logic [6:0] year_q, year_d;
    logic [NUM_ALARMS-1:0][5:0] amin_q, amin_d;
    logic [NUM_ALARMS-1:0][4:0] ahrs_q, ahrs_d;
    logic [NUM_ALARMS-1:0]      edit, ring;
    logic ts, as, leap_cur, leap_nxt;

    function automatic logic [4:0] dim(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                    dim = leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
            default:                 dim = 5'd31;
        endcase
    endfunction

`ifdef LEAP_YEAR_EN
    assign leap_cur = (year_q[1:0] == 2'b00);
    assign leap_nxt = (year_d[1:0] == 2'b00);
`else
    assign leap_cur = 1'b0;
    assign leap_nxt = 1'b0;
`endif

    assign ts      = Timeset_i & ~Alarmset_i;
    assign as      = Alarmset_i & ~Timeset_i;
    assign dim_cur = dim(mon_q, leap_cur);
    assign dim_nxt = dim(mon_d, leap_nxt);

    always_comb begin
        sec_d    = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
        min_d    = min_q;
        hrs_d    = hrs_q;
        dow_d    = dow_q;
        date_raw = date_q;
        mon_d    = mon_q;
        year_d   = year_q;
        if (ts) begin
            if (Minadv_i)   min_d  = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            if (Hrsadv_i)   hrs_d  = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
            if (Monthadv_i) mon_d  = (mon_q == 4'd12) ? 4'd1 : mon_q + 4'd1;
            if (Yearadv_i)  year_d = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
            if (Dateadv_i) begin
                date_raw = (date_q >= dim_cur) ? 5'd1 : date_q + 5'd1;
                dow_d    = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
            end
        end else if (sec_q == 6'd59) begin
            min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            if (min_q == 6'd59) begin
                hrs_d = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
                if (hrs_q == 5'd23) begin
                    dow_d = (dow_q == 3'd6) ? 3'd0 : dow_q + 3'd1;
                    if (date_q >= dim_cur) begin
                        date_raw = 5'd1;
                        mon_d    = (mon_q == 4'd12) ? 4'd1 : mon_q + 4'd1;
                        if (mon_q == 4'd12) year_d = (year_q == 7'd99) ? 7'd0 : year_q + 7'd1;
                    end else begin
                        date_raw = date_q + 5'd1;
                    end
                end
            end
        end
    end

    // Month/Year edits can shrink the month under the current date.
    assign date_d = (date_raw > dim_nxt) ? dim_nxt : date_raw;

    // Display is registered: it follows Alarmset/Alarmsel on the next Pulse.
    always_comb begin
        amin_d = amin_q;
        ahrs_d = ahrs_q;
        edit   = '0;
        dmin_d = min_d;
        dhrs_d = hrs_d;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (as && Alarmsel_i == SELW'(i)) begin
                edit[i] = Minadv_i | Hrsadv_i;
                if (Minadv_i) amin_d[i] = (amin_q[i] == 6'd59) ? 6'd0 : amin_q[i] + 6'd1;
                if (Hrsadv_i) ahrs_d[i] = (ahrs_q[i] == 5'd23) ? 5'd0 : ahrs_q[i] + 5'd1;
            end
        end
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (Alarmset_i && Alarmsel_i == SELW'(i)) begin
                dmin_d = amin_d[i];
                dhrs_d = ahrs_d[i];
            end
        end
    end

    always_ff @(posedge Pulse_i or negedge Reset_i) begin
        if (!Reset_i) begin
            sec_q  <= 6'd0;
            min_q  <= 6'd0;
            hrs_q  <= 5'd0;
            dow_q  <= 3'd0;
            date_q <= 5'd1;
            mon_q  <= 4'd1;
            year_q <= 7'd0;
            amin_q <= '0;
            ahrs_q <= '0;
            dmin_q <= 6'd0;
            dhrs_q <= 5'd0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hrs_q  <= hrs_d;
            dow_q  <= dow_d;
            date_q <= date_d;
            mon_q  <= mon_d;
            year_q <= year_d;
            amin_q <= amin_d;
            ahrs_q <= ahrs_d;
            dmin_q <= dmin_d;
            dhrs_q <= dhrs_d;
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        mac_channel #(.SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) u_ch (
            .Pulse_i (Pulse_i),
            .Reset_i (Reset_i),
            .on_i    (Alarmon_i[g]),
            .snooze_i(Snooze_i),
            .edit_i  (edit[g]),
            .nsec_i  (sec_d),
            .nmin_i  (min_d),
            .nhrs_i  (hrs_d),
            .cmin_i  (min_q),
            .chrs_i  (hrs_q),
            .amin_i  (amin_q[g]),
            .ahrs_i  (ahrs_q[g]),
            .ring_o  (ring[g])
        );
    end

    assign Sec_o     = sec_q;
    assign Min_o     = min_q;
    assign Hrs_o     = hrs_q;
    assign Dow_o     = dow_q;
    assign Date_o    = date_q;
    assign Month_o   = mon_q;
    assign Year_o    = year_q;
    assign DispMin_o = dmin_q;
    assign DispHrs_o = dhrs_q;
    assign BuzzCh_o  = ring;
    assign Buzz_o    = |ring;
endmodule

// File: tb/tb_multi_alarm_calendar.sv
// Scoreboard bench for multi_alarm_calendar (NUM_ALARMS=2, SNOOZE_MIN=9, RING_SEC=60).
// Expected snapshots are queued as stimulus is driven, then popped and compared against the outputs.

module tb_multi_alarm_calendar;
    logic       Pulse, Reset, Timeset, Alarmset, Alarmsel;
    logic       Minadv, Hrsadv, Dateadv, Monthadv, Yearadv, Snooze;
    logic [1:0] Alarmon, BuzzCh;
    logic [5:0] Sec, Min, DispMin;
    logic [4:0] Hrs, Date, DispHrs;
    logic [2:0] Dow;
    logic [3:0] Month;
    logic [6:0] Year;
    logic       Buzz;

    typedef struct { string name; logic [49:0] v; logic [49:0] m; } exp_t;
    exp_t sbq[$];
    exp_t e;
    int   checks = 0, failures = 0;
    logic [49:0] M_ALL, M_TB, M_DISP, M_BZ, M_NODOW, M_CLAMP, M_TD;

    multi_alarm_calendar #(.NUM_ALARMS(2), .SNOOZE_MIN(9), .RING_SEC(60)) dut (
        .Pulse_i(Pulse), .Reset_i(Reset), .Timeset_i(Timeset), .Alarmset_i(Alarmset),
        .Alarmsel_i(Alarmsel), .Minadv_i(Minadv), .Hrsadv_i(Hrsadv), .Dateadv_i(Dateadv),
        .Monthadv_i(Monthadv), .Yearadv_i(Yearadv), .Alarmon_i(Alarmon), .Snooze_i(Snooze),
        .Sec_o(Sec), .Min_o(Min), .Hrs_o(Hrs), .Dow_o(Dow), .Date_o(Date), .Month_o(Month),
        .Year_o(Year), .DispMin_o(DispMin), .DispHrs_o(DispHrs), .Buzz_o(Buzz), .BuzzCh_o(BuzzCh)
    );

    initial Pulse = 1'b0;
    always #5 Pulse = ~Pulse;

    function automatic logic [49:0] snap(int s, int mi, int h, int dw, int dt, int mo, int yr,
                                         int dm, int dh, int bz, int ch);
        return {6'(s), 6'(mi), 5'(h), 3'(dw), 5'(dt), 4'(mo), 7'(yr), 6'(dm), 5'(dh), 1'(bz), 2'(ch)};
    endfunction

    function automatic logic [49:0] obs();
        return {Sec, Min, Hrs, Dow, Date, Month, Year, DispMin, DispHrs, Buzz, BuzzCh};
    endfunction

    task automatic push(string n, logic [49:0] v, logic [49:0] m);
        exp_t x;
        x.name = n; x.v = v; x.m = m;
        sbq.push_back(x);
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge Pulse);
            #1;
        end
    endtask

    task automatic do_reset();
        Timeset = 0; Alarmset = 0; Alarmsel = 0; Minadv = 0; Hrsadv = 0; Dateadv = 0;
        Monthadv = 0; Yearadv = 0; Alarmon = 2'b00; Snooze = 0;
        Reset = 0;
        #2;
        Reset = 1;
    endtask

    // Holds Timeset and pulses each adv line the given number of times (in parallel).
    task automatic adv(int mo, int yr, int dt, int hr, int mi);
        int n;
        n = mo;
        if (yr > n) n = yr;
        if (dt > n) n = dt;
        if (hr > n) n = hr;
        if (mi > n) n = mi;
        Timeset = 1;
        for (int p = 0; p < n; p++) begin
            Monthadv = (p < mo); Yearadv = (p < yr); Dateadv = (p < dt);
            Hrsadv = (p < hr); Minadv = (p < mi);
            tick(1);
        end
        Monthadv = 0; Yearadv = 0; Dateadv = 0; Hrsadv = 0; Minadv = 0;
    endtask

    // Waits in time-set mode (no carries) until Sec=59, then returns to normal mode.
    task automatic sync59();
        for (int k = 0; k < 62 && Sec != 6'd59; k++) tick(1);
        Timeset = 0;
        checks++;
        if (Sec !== 6'd59) begin
            failures++;
            $display("FAIL sync59: Sec=%0d expected 59", Sec);
        end
    endtask

    // Reset, program channel 1 to hr:mi, set the clock to hr:(mi-1):59, take one Pulse.
    task automatic ring_at(int hr, int mi);
        int n;
        do_reset();
        n = (hr > mi) ? hr : mi;
        Alarmset = 1; Alarmsel = 1;
        for (int p = 0; p < n; p++) begin
            Minadv = (p < mi); Hrsadv = (p < hr);
            tick(1);
        end
        Minadv = 0; Hrsadv = 0; Alarmset = 0;
        adv(0, 0, 0, hr, mi - 1);
        Alarmon = 2'b10;
        sync59();
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        tick(5);
        #2;
        Reset = 0;
        #1;
        push("reset", snap(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), M_ALL);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        Reset = 1;
    endtask

    task automatic test_mode_conflict();
        do_reset();
        Timeset = 1; Alarmset = 1; Minadv = 1; Hrsadv = 1; Dateadv = 1; Monthadv = 1; Yearadv = 1;
        push("both_modes", snap(3, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), M_ALL);
        tick(3);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
    endtask

    task automatic test_year_carry();
        do_reset();
        adv(11, 99, 216, 23, 59);
        sync59();
        push("pre_newyear", snap(59, 59, 23, 6, 31, 12, 99, 59, 23, 0, 0), M_ALL);
        push("newyear", snap(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), M_ALL);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        tick(1);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
    endtask

    task automatic test_leap();
        do_reset();
        adv(1, 4, 27, 23, 59);
        sync59();
`ifdef LEAP_YEAR_EN
        push("feb_y4", snap(0, 0, 0, 0, 29, 2, 4, 0, 0, 0, 0), M_NODOW);
`else
        push("feb_y4", snap(0, 0, 0, 0, 1, 3, 4, 0, 0, 0, 0), M_NODOW);
`endif
        tick(1);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        do_reset();
        adv(1, 5, 27, 23, 59);
        sync59();
        push("feb_y5", snap(0, 0, 0, 0, 1, 3, 5, 0, 0, 0, 0), M_NODOW);
        tick(1);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        adv(0, 1, 30, 0, 0);
        Monthadv = 1;
        push("clamp_jan31", snap(0, 0, 0, 0, 28, 2, 1, 0, 0, 0, 0), M_CLAMP);
        tick(1);
        Monthadv = 0; Timeset = 0;
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
    endtask

    task automatic test_display();
        do_reset();
        Alarmset = 1; Alarmsel = 1;
        for (int p = 0; p < 12; p++) begin
            Minadv = 1; Hrsadv = (p < 5);
            tick(1);
        end
        Minadv = 0; Hrsadv = 0;
        push("disp_ch1", snap(12, 0, 0, 0, 0, 0, 0, 12, 5, 0, 0), M_TD);
        push("disp_ch0", snap(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_TD);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        Alarmsel = 0;
        tick(1);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        Alarmset = 0;
    endtask

    task automatic test_ring_timeout();
        push("ring_start", snap(0, 30, 7, 0, 0, 0, 0, 30, 7, 1, 2), M_TB | M_DISP);
        push("ring_59s", snap(59, 30, 7, 0, 0, 0, 0, 0, 0, 1, 2), M_TB);
        push("ring_60s", snap(0, 31, 7, 0, 0, 0, 0, 0, 0, 0, 0), M_TB);
        ring_at(7, 30);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        tick(59);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        tick(1);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
    endtask

    task automatic test_snooze();
        ring_at(7, 30);
        tick(10);
        Snooze = 1;
        push("snooze_off", snap(11, 30, 7, 0, 0, 0, 0, 0, 0, 0, 0), M_TB);
        tick(1);
        Snooze = 0;
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        push("snooze_ring", snap(0, 39, 7, 0, 0, 0, 0, 0, 0, 1, 2), M_TB);
        for (int k = 0; k < 700 && Buzz !== 1'b1; k++) tick(1);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        Alarmon = 2'b00;
        push("alarmon_off", snap(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_BZ);
        tick(1);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
    endtask

    task automatic test_midnight_snooze();
        ring_at(23, 55);
        push("ring_2355", snap(0, 55, 23, 0, 0, 0, 0, 0, 0, 1, 2), M_TB);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        tick(10);
        Snooze = 1;
        tick(1);
        Snooze = 0;
        push("snooze_0004", snap(0, 4, 0, 1, 2, 1, 0, 4, 0, 1, 2), M_ALL);
        for (int k = 0; k < 700 && Buzz !== 1'b1; k++) tick(1);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
    endtask

    task automatic test_reset_midring();
        #2;
        Reset = 0;
        #1;
        push("reset_midring", snap(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), M_ALL);
        e = sbq.pop_front(); checks++;
        if ((obs() & e.m) !== (e.v & e.m)) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, obs() & e.m, e.v & e.m);
        end
        Reset = 1;
    endtask

    initial begin
        M_ALL   = '1;
        M_TB    = snap(63, 63, 31, 0, 0, 0, 0, 0, 0, 1, 3);
        M_DISP  = snap(0, 0, 0, 0, 0, 0, 0, 63, 31, 0, 0);
        M_BZ    = snap(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3);
        M_NODOW = ~snap(0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        M_CLAMP = snap(0, 63, 31, 0, 31, 15, 127, 0, 0, 0, 0);
        M_TD    = snap(63, 63, 31, 0, 0, 0, 0, 63, 31, 0, 0);
        Reset = 1;
        test_reset();
        test_mode_conflict();
        test_year_carry();
        test_leap();
        test_clamp();
        test_display();
        test_ring_timeout();
        test_snooze();
        test_midnight_snooze();
        test_reset_midring();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_alarm_calendar.md
MULTI_ALARM_CALENDAR -- requirements
Module: multi_alarm_calendar

Interface
REQ-001 Parameter NUM_ALARMS, default 2, number of independent alarm channels (1..8).
REQ-002 Parameter SNOOZE_MIN, default 9, snooze delay in minutes (1..59).
REQ-003 Parameter RING_SEC, default 60, auto-silence timeout in seconds (1..255).
REQ-004 Pulse  in  1  clock, one rising edge per second.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 Timeset, Alarmset  in  1 each  mode selects: time-set and alarm-set.
REQ-007 Alarmsel  in  max(1,$clog2(NUM_ALARMS))  alarm channel being set or displayed.
REQ-008 Minadv, Hrsadv, Dateadv, Monthadv, Yearadv  in  1 each  advance requests.
REQ-009 Alarmon  in  NUM_ALARMS  per-channel alarm enable.
REQ-010 Snooze  in  1  snooze request.
REQ-011 Sec, Min  out  6 each  current time of day, 0..59.
REQ-012 Hrs  out  5  current time of day, 0..23.
REQ-013 Dow  out  3  day of week, 0..6.
REQ-014 Date  out  5  day of month, 1..31.
REQ-015 Month  out  4  month, 1..12.
REQ-016 Year  out  7  year within the century, 0..99.
REQ-017 DispMin  out  6  minutes shown on the display.
REQ-018 DispHrs  out  5  hours shown on the display.
REQ-019 Buzz  out  1  OR of all channel ring states.
REQ-020 BuzzCh  out  NUM_ALARMS  per-channel ring state.

Function
REQ-021 All state SHALL update on rising Pulse; all outputs SHALL be registered or decoded from registers, with no combinational path from inputs to Buzz.
REQ-022 Sec SHALL increment every Pulse mod 60 in all modes.
REQ-023 Normal mode (Timeset=0) carry chain: Min advances when Sec=59; Hrs when Sec=59 and Min=59; Date and Dow when the time is also Hrs=23.
REQ-024 Date carry: Date wraps to 1 and Month advances when Date=days_in_month(Month,Year); Month wraps 12->1 and Year advances; Year wraps 99->0.
REQ-025 days_in_month: 30 for months 4/6/9/11, 31 for the other non-February months, February per REQ-040/041.
REQ-026 Time-set mode (Timeset=1, Alarmset=0): each asserted *adv advances its field by one per Pulse with wrap and no carry into other fields; the normal Min..Year carries are suppressed; Sec keeps running.
REQ-027 In time-set mode, Dateadv SHALL also advance Dow by one.
REQ-028 After any Month or Year change, if Date exceeds the new days_in_month, Date SHALL clamp to that maximum in the same cycle.
REQ-029 Alarm-set mode (Alarmset=1, Timeset=0): Minadv and Hrsadv advance alarm register Alarmsel with wrap; all other channels hold.
REQ-030 Timeset=1 and Alarmset=1 together: no field adjusts; time runs as in normal mode.
REQ-031 DispMin/DispHrs SHALL show alarm register Alarmsel when Alarmset=1, else Min/Hrs.
REQ-032 Channel i SHALL start ringing (BuzzCh[i]=1) when Alarmon[i]=1, Sec=0, and Min/Hrs equal the channel's target.
REQ-033 Channel target SHALL equal its alarm register unless a snooze target is pending.
REQ-034 A ringing channel SHALL stop when Alarmon[i]=0, or after RING_SEC Pulses (per-channel 8-bit counter).
REQ-035 Snooze=1 SHALL silence every ringing channel and set its pending target to current time + SNOOZE_MIN minutes, mod 24 h.
REQ-036 The pending target SHALL clear when that snoozed alarm fires or Alarmon[i] falls.
REQ-037 Snooze SHALL be ignored for channels not ringing; a new match on an already-ringing channel SHALL not restart its counter.
REQ-038 An alarm-register edit on channel i SHALL clear that channel's pending snooze target.

Reset
REQ-039 Reset=0 SHALL asynchronously force Sec=Min=Hrs=0, Dow=0, Date=1, Month=1, Year=0, all alarm registers 00:00, all snooze targets and ring counters cleared, Buzz=0, BuzzCh=0; Reset asserted mid-ring SHALL drop Buzz immediately, without waiting for a Pulse edge.

Configuration
REQ-040 With macro LEAP_YEAR_EN defined, February SHALL have 29 days when Year mod 4 = 0, else 28.
REQ-041 With LEAP_YEAR_EN undefined, February SHALL always have 28 days and no leap logic is synthesized.

Verification
REQ-042 Set Dec 31 year 99, 23:59:59, Dow=6; one Pulse -> 00:00:00, Jan 1, Year 0, Dow 0.
REQ-043 With LEAP_YEAR_EN: Feb 28, Year 4, 23:59:59 -> Feb 29; Year 5 -> Mar 1; without the macro, Year 4 -> Mar 1.
REQ-044 Jan 31, Timeset=1, Monthadv one Pulse -> Month 2, Date 28 (clamp).
REQ-045 NUM_ALARMS=2, ch1=07:30, Alarmon=2'b10 -> at 07:30:00 BuzzCh=2'b10 and Buzz=1; with no action, Buzz=0 after 60 Pulses.
REQ-046 Ringing ch1, Snooze at 07:30:10 -> Buzz=0 next edge; rings again at 07:39:00; alarm at 23:55 snoozed -> rings at 00:04:00.
REQ-047 Reset low between Pulse edges while ringing -> Buzz=0 at once; all fields read back their reset values.
